tcs3472_sampler: RTL and testbench
==================================

// Module: tcs3472_sampler
// PURPOSE
// - Upstream command sequencer for the i2c_refactor byte-level I2C master (TCS3472 colour sensor, addr 7'h29).
// - Configures the sensor once, then periodically reads C/R/G/B low/high bytes (8 single-byte reads).
// - Assembles the bytes into four 16-bit channels and publishes them with a one-cycle valid strobe.
// PARAMETERS
// - DEV_ADDR        7'h29    I2C 7-bit device address driven on i2c_addr
// - CMD_BIT         8'h80    OR-ed into every register address (TCS3472 command bit)
// - ATIME_VAL       8'hF6    value written to ATIME (0x01)
// - GAIN_VAL        8'h01    value written to CONTROL (0x0F), 4x gain
// - PON_WAIT_CYC    150000   cycles between PON write and AEN write (>=2.4 ms at 50 MHz)
// - PERIOD_CYC      2500000  cycles from one burst start to the next
// - TIMEOUT_CYC     200000   per-transaction watchdog limit (TCS_TIMEOUT_EN only)
// PORTS
// - clk           in   1   system clock
// - rst           in   1   synchronous reset, active low
// - en            in   1   1 = run sampling; 0 = finish current burst, then hold in WAIT_PERIOD
// - i2c_start     out  1   transaction request to master
// - i2c_rw        out  1   1 = read, 0 = write
// - i2c_addr      out  7   device address (DEV_ADDR)
// - i2c_reg_addr  out  8   CMD_BIT | register
// - i2c_data_in   out  8   write data to master
// - i2c_data_out  in   8   read data from master
// - i2c_done      in   1   transaction complete from master
// - clear/red/green/blue  out 16 each  latest channel values
// - valid         out  1   one-cycle strobe: all four channels updated
// - busy          out  1   1 while any I2C transaction is outstanding
// - err           out  1   sticky watchdog error (TCS_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
// - Reset (rst=0 at clk edge): all outputs 0, i2c_rw=1, state INIT_PON, timers/byte index 0.
// - Transaction handshake (three phases per transaction):
//   ISSUE: drive rw/reg_addr/data_in, i2c_start=1; held stable while i2c_start=1.
//   WAIT_DONE: i2c_start stays 1 until i2c_done sampled 1; capture i2c_data_out that same cycle; drop start next cycle.
//   RELEASE: wait for i2c_done=0 before the next ISSUE (works with level or pulsed done).
// - State sequence:
//   INIT_PON  write 0x00 <- 8'h01 -> WAIT_PON (count PON_WAIT_CYC)
//   INIT_ATIME write 0x01 <- ATIME_VAL; INIT_CTRL write 0x0F <- GAIN_VAL
//   INIT_AEN  write 0x00 <- 8'h03 -> WAIT_PERIOD
//   WAIT_PERIOD: when period counter hits PERIOD_CYC-1 and en=1 -> READ, idx=0
//   READ idx 0..7: reg = 0x14+idx (CDATAL..BDATAH); even idx -> low byte, odd -> high byte of shadow reg
//   after idx 7 -> PUBLISH -> WAIT_PERIOD
// - PUBLISH: copy all four shadow regs to outputs in one cycle, valid=1 for exactly that cycle;
//   outputs never show a partially updated burst.
// - Period counter free-runs from entry to the first READ; counts up to PERIOD_CYC-1, wraps to 0; if burst
//   outlasts the period the next burst starts immediately after PUBLISH (no overlap, no queueing).
// - en deasserted mid-burst: burst completes and publishes; no new burst while en=0.
// - busy = 1 from ISSUE entry until RELEASE exit.
// - rst asserted mid-transaction: i2c_start drops at the same edge, sequence restarts at INIT_PON.
// CONFIGURATION
// - TCS_TIMEOUT_EN defined: counter runs in WAIT_DONE/RELEASE; reaching TIMEOUT_CYC -> start=0,
//   err=1 (sticky until reset), shadow regs discarded, no valid, restart at INIT_PON.
// - TCS_TIMEOUT_EN undefined: no counter, waits indefinitely for done; err tied 0.
// STRUCTURE
// - Shared header tcs3472_defs.vh: register addresses (ENABLE, ATIME, CONTROL, CDATAL), ENABLE bit
//   values (PON, AEN), CMD_BIT default, state encodings.
// - One sub-module: tcs_txn_ctrl (ISSUE/WAIT_DONE/RELEASE handshake + optional watchdog);
//   the top holds the sequencing FSM, byte index, timers, shadow regs.
// TESTING
// - Reset: hold rst=0 5 cycles -> all outputs 0, i2c_start=0; after release first ISSUE is write reg 0x80, data 0x01.
// - Init: slave model ACKs all -> writes observed in order 0x80/01, 0x81/F6, 0x8F/01, 0x80/03; AEN no earlier than PON_WAIT_CYC.
// - Burst: slave memory 0x14..0x1B = 11,22,33,44,55,66,77,88 -> clear=16'h2211, red=16'h4433,
//   green=16'h6655, blue=16'h8877, valid high exactly 1 cycle.
// - Pulsed vs level done: 1-cycle done and done held 10 cycles -> exactly one capture per read, 8 reads/burst.
// - en=0 at idx 3 -> burst completes, one valid, then no i2c_start for 3*PERIOD_CYC; en=1 resumes.
// - TCS_TIMEOUT_EN, slave never raises done -> err=1 after TIMEOUT_CYC, start dropped, restart at INIT_PON, outputs unchanged.

Source files
------------

// File: rtl/tcs3472_sampler_pkg.sv
// tcs3472_sampler_pkg: TCS3472 register map, ENABLE bit values and FSM encodings.
package tcs3472_sampler_pkg;
  localparam logic [7:0] CMD_BIT_DEF = 8'h80;
  localparam logic [7:0] REG_ENABLE = 8'h00;
  localparam logic [7:0] REG_ATIME = 8'h01;
  localparam logic [7:0] REG_CONTROL = 8'h0F;
  localparam logic [7:0] REG_CDATAL = 8'h14;
  localparam logic [7:0] EN_PON = 8'h01;
  localparam logic [7:0] EN_AEN = 8'h02;
  typedef enum logic [2:0] {S_PON, S_WPON, S_ATIME, S_CTRL, S_AEN, S_WPER, S_READ, S_PUB} seq_t;
  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_REL} txn_t;
endpackage

// File: rtl/tcs_txn_ctrl.sv
// tcs_txn_ctrl: ISSUE/WAIT_DONE/RELEASE handshake towards the byte-level I2C master.
// TCS_TIMEOUT_EN adds a per-transaction watchdog.
module tcs_txn_ctrl
  import tcs3472_sampler_pkg::*;
#(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic done,
  output logic start,
  output logic busy,
  output logic cap,
  output logic fin,
  output logic tmo
);
  txn_t st, nxt;
  always_ff @(posedge clk)
    if (!rst) st <= T_IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      T_IDLE: nxt = req ? T_WAIT : T_IDLE;
      T_WAIT: nxt = done ? T_REL : T_WAIT;
      default: nxt = done ? T_REL : T_IDLE;
    endcase
    if (tmo) nxt = T_IDLE;
  end
  assign start = st == T_WAIT;
  assign busy = st != T_IDLE;
  assign cap = st == T_WAIT && done && !tmo;
  assign fin = st == T_REL && !done && !tmo;
`ifdef TCS_TIMEOUT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk)
    if (!rst) cnt <= 32'd0;
    else cnt <= (busy && !tmo) ? cnt + 32'd1 : 32'd0;
  assign tmo = busy && cnt == 32'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
endmodule

// File: rtl/tcs3472_sampler.sv
// tcs3472_sampler: configures a TCS3472 and periodically reads its C/R/G/B channels over I2C.
// TCS_TIMEOUT_EN enables the transaction watchdog and sticky err.
module tcs3472_sampler
  import tcs3472_sampler_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h29,
  parameter logic [7:0] CMD_BIT = CMD_BIT_DEF,
  parameter logic [7:0] ATIME_VAL = 8'hF6,
  parameter logic [7:0] GAIN_VAL = 8'h01,
  parameter int PON_WAIT_CYC = 150000,
  parameter int PERIOD_CYC = 2500000,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        i2c_start,
  output logic        i2c_rw,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_data_in,
  input  logic [7:0]  i2c_data_out,
  input  logic        i2c_done,
  output logic [15:0] clear,
  output logic [15:0] red,
  output logic [15:0] green,
  output logic [15:0] blue,
  output logic        valid,
  output logic        busy,
  output logic        err
);
  seq_t st, nxt;
  logic req, cap, fin, tmo, rd, pend, samp, per_hit;
  logic [7:0] reg_sel, wdat;
  logic [2:0] idx;
  logic [31:0] pon_cnt, per_cnt;
  logic [7:0] sh [8];
  tcs_txn_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_txn (
    .clk(clk), .rst(rst), .req(req), .done(i2c_done),
    .start(i2c_start), .busy(busy), .cap(cap), .fin(fin), .tmo(tmo)
  );
  assign samp = st == S_WPER || st == S_READ || st == S_PUB;
  assign per_hit = per_cnt == 32'(PERIOD_CYC - 1);
  always_comb begin
    nxt = st;
    req = 1'b0;
    rd = 1'b0;
    reg_sel = REG_ENABLE;
    wdat = 8'h00;
    case (st)
      S_PON: begin req = 1'b1; wdat = EN_PON; nxt = fin ? S_WPON : st; end
      S_WPON: nxt = pon_cnt == 32'(PON_WAIT_CYC - 1) ? S_ATIME : st;
      S_ATIME: begin req = 1'b1; reg_sel = REG_ATIME; wdat = ATIME_VAL; nxt = fin ? S_CTRL : st; end
      S_CTRL: begin req = 1'b1; reg_sel = REG_CONTROL; wdat = GAIN_VAL; nxt = fin ? S_AEN : st; end
      S_AEN: begin req = 1'b1; wdat = EN_PON | EN_AEN; nxt = fin ? S_WPER : st; end
      S_WPER: nxt = en && (per_hit || pend) ? S_READ : st;
      S_READ: begin req = 1'b1; rd = 1'b1; reg_sel = REG_CDATAL + {5'd0, idx}; nxt = fin && idx == 3'd7 ? S_PUB : st; end
      default: nxt = S_WPER;
    endcase
    if (tmo) nxt = S_PON;
  end
  // Transaction fields are zero (rw=1) whenever no transaction is outstanding.
  assign i2c_rw = busy ? rd : 1'b1;
  assign i2c_addr = busy ? DEV_ADDR : 7'd0;
  assign i2c_reg_addr = busy ? (CMD_BIT | reg_sel) : 8'h00;
  assign i2c_data_in = busy ? wdat : 8'h00;
  always_ff @(posedge clk)
    if (!rst) begin
      st <= S_PON;
      pon_cnt <= 32'd0;
      per_cnt <= 32'd0;
      pend <= 1'b0;
      idx <= 3'd0;
      sh <= '{default: 8'h00};
      {clear, red, green, blue} <= 64'd0;
      valid <= 1'b0;
    end else begin
      st <= nxt;
      pon_cnt <= st == S_WPON ? pon_cnt + 32'd1 : 32'd0;
      per_cnt <= samp ? (per_hit ? 32'd0 : per_cnt + 32'd1) : 32'd0;
      // A period boundary missed during a long burst starts the next burst right after PUBLISH.
      pend <= (!samp || (st == S_WPER && nxt == S_READ)) ? 1'b0 : (per_hit && st != S_WPER) ? 1'b1 : pend;
      idx <= st == S_READ ? idx + {2'd0, fin} : 3'd0;
      if (tmo) sh <= '{default: 8'h00};
      else if (cap && st == S_READ) sh[idx] <= i2c_data_out;
      valid <= st == S_PUB;
      if (st == S_PUB) {clear, red, green, blue} <= {sh[1], sh[0], sh[3], sh[2], sh[5], sh[4], sh[7], sh[6]};
    end
`ifdef TCS_TIMEOUT_EN
  always_ff @(posedge clk)
    if (!rst) err <= 1'b0;
    else err <= err | tmo;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_tcs3472_sampler.sv
// tb_tcs3472_sampler: directed bench with a small I2C slave model and per-scenario tasks.
module tb_tcs3472_sampler;
  localparam int PON = 20, PER = 300, TMO = 40;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic i2c_start, i2c_rw, valid, busy, err;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_reg_addr, i2c_data_in;
  logic [7:0] i2c_data_out = 8'h00;
  logic i2c_done = 1'b0;
  logic [15:0] clear, red, green, blue;
  typedef struct {logic rw; logic [6:0] a; logic [7:0] ra; logic [7:0] wd; int c;} tx_t;
  tx_t log_q[$];
  logic [7:0] mem [128];
  int checks = 0, errors = 0, cyc = 0, vcnt = 0, dly = 2, hold = 1;
  bit silent = 1'b0;

  tcs3472_sampler #(.PON_WAIT_CYC(PON), .PERIOD_CYC(PER), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr),
    .i2c_reg_addr(i2c_reg_addr), .i2c_data_in(i2c_data_in), .i2c_data_out(i2c_data_out),
    .i2c_done(i2c_done), .clear(clear), .red(red), .green(green), .blue(blue),
    .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (valid) vcnt++;

  initial begin : slave
    forever begin
      @(negedge clk);
      if (i2c_start && !silent) begin
        log_q.push_back('{i2c_rw, i2c_addr, i2c_reg_addr, i2c_data_in, cyc});
        repeat (dly) @(negedge clk);
        i2c_data_out = mem[i2c_reg_addr[6:0]];
        i2c_done = 1'b1;
        repeat (hold) @(negedge clk);
        i2c_done = 1'b0;
      end
    end
  end

  task automatic wait_valid(input int lim, output bit ok);
    int v0 = vcnt;
    ok = 1'b0;
    for (int n = 0; n < lim && !ok; n++) begin
      @(negedge clk);
      ok = vcnt != v0;
    end
  endtask

  task automatic load_mem(input logic [7:0] base);
    for (int i = 0; i < 8; i++) mem[8'h14 + i] = base + 8'(i);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", i2c_start); end
    checks++; if ({busy, valid, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, valid, err}); end
    checks++; if ({clear, red, green, blue} !== 64'd0) begin errors++; $display("FAIL reset_chan got %h exp 0", {clear, red, green, blue}); end
    checks++; if ({i2c_rw, i2c_addr, i2c_reg_addr, i2c_data_in} !== {1'b1, 23'd0}) begin errors++; $display("FAIL reset_bus got %h exp %h", {i2c_rw, i2c_addr, i2c_reg_addr, i2c_data_in}, {1'b1, 23'd0}); end
    rst = 1'b1;
  endtask

  task automatic test_init;
    logic [15:0] exp [4] = '{16'h8001, 16'h81F6, 16'h8F01, 16'h8003};
    for (int n = 0; n < 2000 && log_q.size() < 4; n++) @(negedge clk);
    checks++;
    if (log_q.size() < 4) begin errors++; $display("FAIL init_count got %0d exp 4", log_q.size()); return; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({log_q[i].rw, log_q[i].ra, log_q[i].wd} !== {1'b0, exp[i]})
        begin errors++; $display("FAIL init_write%0d got %h exp %h", i, {log_q[i].rw, log_q[i].ra, log_q[i].wd}, {1'b0, exp[i]}); end
    end
    checks++; if (log_q[0].a !== 7'h29) begin errors++; $display("FAIL init_addr got %h exp 29", log_q[0].a); end
    checks++; if (log_q[3].c - log_q[0].c < PON) begin errors++; $display("FAIL init_pon_wait got %0d exp >=%0d", log_q[3].c - log_q[0].c, PON); end
  endtask

  task automatic test_burst;
    bit ok;
    int v0 = vcnt, bad = 0, n;
    en = 1'b1;
    wait_valid(PER + 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_valid got none exp 1"); return; end
    checks++;
    if ({clear, red, green, blue} !== 64'h2211_4433_6655_8877) begin errors++; $display("FAIL burst_data got %h exp 2211443366558877", {clear, red, green, blue}); end
    n = log_q.size();
    for (int i = 0; i < 8; i++) if ({log_q[n - 8 + i].rw, log_q[n - 8 + i].ra} !== {1'b1, 8'h94 + 8'(i)}) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL burst_reads got %0d bad exp 0", bad); end
    repeat (3) @(negedge clk);
    checks++; if (vcnt - v0 != 1) begin errors++; $display("FAIL burst_valid_width got %0d exp 1", vcnt - v0); end
  endtask

  task automatic test_level_done;
    bit ok;
    int v0 = vcnt, n0 = log_q.size();
    hold = 10; dly = 1;
    load_mem(8'hA1);
    wait_valid(PER + 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL level_valid got none exp 1"); return; end
    checks++;
    if ({clear, red, green, blue} !== 64'hA2A1_A4A3_A6A5_A8A7) begin errors++; $display("FAIL level_data got %h exp A2A1A4A3A6A5A8A7", {clear, red, green, blue}); end
    checks++; if (log_q.size() - n0 != 8) begin errors++; $display("FAIL level_reads got %0d exp 8", log_q.size() - n0); end
    repeat (3) @(negedge clk);
    checks++; if (vcnt - v0 != 1) begin errors++; $display("FAIL level_valid_width got %0d exp 1", vcnt - v0); end
    hold = 1; dly = 2;
  endtask

  task automatic test_en_off;
    bit ok;
    int v0, n0, starts = 0, k;
    load_mem(8'hB1);
    for (k = 0; k < PER + 500; k++) begin
      @(negedge clk);
      if (log_q.size() > 0 && log_q[log_q.size() - 1].ra == 8'h97) break;
    end
    checks++; if (k == PER + 500) begin errors++; $display("FAIL enoff_idx3 got none exp read 97"); return; end
    en = 1'b0;
    v0 = vcnt;
    wait_valid(500, ok);
    checks++;
    if (!ok || {clear, red, green, blue} !== 64'hB2B1_B4B3_B6B5_B8B7) begin errors++; $display("FAIL enoff_data got %h exp B2B1B4B3B6B5B8B7", {clear, red, green, blue}); end
    n0 = log_q.size();
    repeat (3 * PER) begin @(negedge clk); if (i2c_start) starts++; end
    checks++; if (starts != 0 || log_q.size() != n0) begin errors++; $display("FAIL enoff_idle got %0d starts exp 0", starts); end
    checks++; if (vcnt - v0 != 1) begin errors++; $display("FAIL enoff_valid_count got %0d exp 1", vcnt - v0); end
    load_mem(8'hC1);
    en = 1'b1;
    wait_valid(2 * PER + 500, ok);
    checks++;
    if (!ok || {clear, red, green, blue} !== 64'hC2C1_C4C3_C6C5_C8C7) begin errors++; $display("FAIL enon_data got %h exp C2C1C4C3C6C5C8C7", {clear, red, green, blue}); end
  endtask

  task automatic test_mid_reset;
    int n0, k;
    for (k = 0; k < PER + 100 && !i2c_start; k++) @(negedge clk);
    checks++; if (!i2c_start) begin errors++; $display("FAIL midrst_start got 0 exp 1"); return; end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL midrst_drop got %b exp 0", i2c_start); end
    checks++; if ({clear, valid} !== 17'd0) begin errors++; $display("FAIL midrst_out got %h exp 0", {clear, valid}); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    n0 = log_q.size();
    for (k = 0; k < 100 && log_q.size() == n0; k++) @(negedge clk);
    checks++;
    if (log_q.size() == n0 || {log_q[n0].rw, log_q[n0].ra, log_q[n0].wd} !== 17'h08001)
      begin errors++; $display("FAIL midrst_restart got %0d entries exp write 80/01", log_q.size() - n0); end
  endtask

`ifdef TCS_TIMEOUT_EN
  task automatic test_timeout;
    int n0, k;
    silent = 1'b1;
    for (k = 0; k < 300 && !err; k++) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", err); end
    checks++; if ({i2c_start, valid, clear} !== 18'd0) begin errors++; $display("FAIL tmo_out got %h exp 0", {i2c_start, valid, clear}); end
    n0 = log_q.size();
    silent = 1'b0;
    for (k = 0; k < 100 && log_q.size() == n0; k++) @(negedge clk);
    checks++;
    if (log_q.size() == n0 || {log_q[n0].rw, log_q[n0].ra, log_q[n0].wd} !== 17'h08001)
      begin errors++; $display("FAIL tmo_restart got %0d entries exp write 80/01", log_q.size() - n0); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", err); end
  endtask
`else
  task automatic test_timeout;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied got %b exp 0", err); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem[8'h14 + i] = 8'h11 * 8'(i + 1);
    test_reset();
    test_init();
    test_burst();
    test_level_done();
    test_en_off();
    test_mid_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
